// File: rtl/alu_arbiter_if.sv
// Bus bundle between the CPU control path, the alu_arbiter and the shared ALU.
// slave  : the arbiter's view (takes requests, drives responses and the ALU inputs).
// master : the environment's view (requesters, response consumers and the ALU itself).
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 4,
  parameter int APSR_WIDTH = 3
);
  // Request side, two requesters (bit i / suffix i = port i)
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [OP_WIDTH-1:0]   req_op0;
  logic [OP_WIDTH-1:0]   req_op1;
  logic [DATA_WIDTH-1:0] req_a0;
  logic [DATA_WIDTH-1:0] req_a1;
  logic [DATA_WIDTH-1:0] req_b0;
  logic [DATA_WIDTH-1:0] req_b1;
  logic [1:0]            req_setf;

  // Response side, result and flags shared by both ports
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic [APSR_WIDTH-1:0] rsp_apsr;
  logic [APSR_WIDTH-1:0] psr_o;

  // Connection to the external combinational ALU
  logic [OP_WIDTH-1:0]   alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [APSR_WIDTH-1:0] alu_psr;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [APSR_WIDTH-1:0] alu_apsr;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_setf,
    output req_ready,
    output rsp_valid, rsp_result, rsp_apsr, psr_o,
    input  rsp_ready,
    output alu_op, alu_a, alu_b, alu_psr,
    input  alu_result, alu_apsr
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, req_setf,
    input  req_ready,
    input  rsp_valid, rsp_result, rsp_apsr, psr_o,
    output rsp_ready,
    input  alu_op, alu_a, alu_b, alu_psr,
    output alu_result, alu_apsr
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute stage
// (port 0) and the address/auxiliary unit (port 1). Owns the APSR (psr_q):
// flag-setting operations write the ALU flags back into it on completion.
// Each transaction runs IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold
// until consumed), so at most one response is outstanding at any time.
// The block is agnostic of the individual flag bit positions; it only moves
// whole flag vectors between the ALU and psr_q.
module alu_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int OP_WIDTH   = 4,
  parameter int APSR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  logic                  last_grant_q;
  logic                  owner_q;
  logic                  setf_q;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [APSR_WIDTH-1:0] psr_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic [APSR_WIDTH-1:0] rsp_apsr_q;
  logic [1:0]            rsp_valid_q;

  // Combinational grant decision for the current IDLE cycle
  logic                  grant_any_d;
  logic                  grant_port_d;
  logic [OP_WIDTH-1:0]   win_op_d;
  logic [DATA_WIDTH-1:0] win_a_d;
  logic [DATA_WIDTH-1:0] win_b_d;
  logic                  win_setf_d;

  // Pick the winner: a lone requester wins, contention goes to the port that lost last time
  always_comb begin
    grant_any_d = (state_q == IDLE) && (|bus.req_valid);
    case (bus.req_valid)
      2'b01:   grant_port_d = 1'b0;
      2'b10:   grant_port_d = 1'b1;
      default: grant_port_d = ~last_grant_q;
    endcase
  end

  // Route the winning port's operation and operands towards the latch registers
  always_comb begin
    win_op_d   = bus.req_op0;
    win_a_d    = bus.req_a0;
    win_b_d    = bus.req_b0;
    win_setf_d = bus.req_setf[0];
    if (grant_port_d) begin
      win_op_d   = bus.req_op1;
      win_a_d    = bus.req_a1;
      win_b_d    = bus.req_b1;
      win_setf_d = bus.req_setf[1];
    end
  end

  // req_ready is combinational so a request is accepted in the cycle it is granted
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign bus.req_ready[gi] = grant_any_d && (grant_port_d == 1'(gi));
    end
  endgenerate

  // Transaction FSM: grant/latch, capture ALU output and flags, hold response until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // port 0 wins the first contended grant
      owner_q      <= 1'b0;
      setf_q       <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      psr_q        <= '0;
      rsp_result_q <= '0;
      rsp_apsr_q   <= '0;
      rsp_valid_q  <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any_d) begin
            op_q         <= win_op_d;
            a_q          <= win_a_d;
            b_q          <= win_b_d;
            setf_q       <= win_setf_d;
            owner_q      <= grant_port_d;
            last_grant_q <= grant_port_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= bus.alu_result;
          rsp_apsr_q   <= bus.alu_apsr;
          rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
          // Undefined ops return psr as flags, so a setf write leaves psr_q unchanged
          if (setf_q) begin
            psr_q <= bus.alu_apsr;
          end
          state_q <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready completes the transaction
          if (bus.rsp_ready[owner_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The ALU sees the latched operation at all times (held while idle) and the live APSR
  assign bus.alu_op  = op_q;
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.alu_psr = psr_q;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_apsr   = rsp_apsr_q;
  assign bus.psr_o      = psr_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational alu instance between two requesters: port 0 is the execute stage and port 1 is the address/auxiliary unit.
- Owns the architectural APSR register (psr_q) that feeds the alu psr input, and updates it on flag-setting operations.
- Each requester uses a valid/ready request handshake and a valid/ready response handshake.
- Sits between the CPU control path and the alu; the alu instance is external and connected through the alu_* ports.

Parameters:
- DATA_WIDTH, `DATA_WIDTH, operand/result width.
- OP_WIDTH, `ALUOP_WIDTH, alu operation code width.
- APSR_WIDTH, `APSR_WIDTH, flag vector width; bit positions follow `APSR_CARRY/`APSR_ZERO/`APSR_NEG.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid, bit i = port i.
- req_ready  output  2  per-requester request accepted.
- req_op0, req_op1  input  OP_WIDTH  alu operation per port.
- req_a0, req_a1  input  DATA_WIDTH  first operand per port.
- req_b0, req_b1  input  DATA_WIDTH  second operand per port.
- req_setf  input  2  per-port: write the alu flags into psr_q on completion.
- rsp_valid  output  2  per-port response valid.
- rsp_ready  input  2  per-port response consumed.
- rsp_result  output  DATA_WIDTH  registered result, shared by both ports, qualified by rsp_valid.
- rsp_apsr  output  APSR_WIDTH  registered alu flags for the transaction.
- psr_o  output  APSR_WIDTH  current psr_q.
- alu_op  output  OP_WIDTH  to alu operation.
- alu_a, alu_b  output  DATA_WIDTH  to alu a_i/b_i.
- alu_psr  output  APSR_WIDTH  to alu psr; always equals psr_q.
- alu_result  input  DATA_WIDTH  from alu result.
- alu_apsr  input  APSR_WIDTH  from alu apsr.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE.
  - psr_q, rsp_result, rsp_apsr, and the latched op/a/b/setf/owner registers = 0.
  - rsp_valid = 2'b00.
  - last_grant = 1, so port 0 wins first.
- Reset asserted mid-transaction: the transaction is dropped, no response is issued, and psr_q returns to 0.
- State IDLE:
  - req_ready is combinational; it is 1 only for the granted port, only in IDLE.
  - Grant rule: if exactly one req_valid bit is set, that port wins. If both are set, the port != last_grant wins (round-robin).
  - On grant: latch op/a/b/setf of the winner and owner = winner; set last_grant = winner; go to EXEC.
  - If no request: stay in IDLE and hold alu_op at the latched value.
- State EXEC (one cycle):
  - alu_op/alu_a/alu_b are driven from the latched registers; alu_psr = psr_q.
  - At the clock edge: rsp_result <= alu_result; rsp_apsr <= alu_apsr; rsp_valid[owner] <= 1.
  - If latched setf = 1: psr_q <= alu_apsr. Otherwise psr_q is unchanged.
  - Go to RESP.
- State RESP:
  - rsp_valid[owner] = 1, and rsp_result/rsp_apsr are held stable until rsp_ready[owner] = 1.
  - On handshake: rsp_valid <= 0; go to IDLE.
  - rsp_ready on the non-owner port is ignored.
- Latency and throughput:
  - Request accepted at edge N; rsp_valid is high from cycle N+2.
  - Minimum 3 cycles per transaction.
  - No new grant while in EXEC or RESP; req_ready = 0 for both ports.
- Carry chaining:
  - ADDC/SUBC consume psr_q carry, i.e. the flags of the last completed setf transaction from either port.
  - Software must keep multi-word sequences on one port without intervening setf ops.
- Undefined op codes: the alu default behaviour applies (result = a, apsr = psr).
  - With setf = 1, psr_q is rewritten with its own value (no change).
- Requester rules: a port must hold valid/op/a/b/setf stable until req_ready. The block does not check this.
- Exactly one rsp_valid bit may be set at any time.

Test Plan:
- Reset, then port0 ADD a=0xFFFF b=0x0001 setf=1:
  - req_ready[0] in the same cycle.
  - rsp_valid[0] two cycles later with result=0x0000, carry=1, zero=1, neg=0.
  - psr_o carry=1.
- Immediately after, port0 ADDC a=0x0001 b=0x0000 setf=1 -> result=0x0002, carry=0; psr_o zero=0.
- Both ports valid every cycle:
  - Grants alternate 0,1,0,1.
  - Each response goes only to its owner.
  - No grant while the other response is unconsumed.
- Port1 XOR a=0x00FF b=0x0F0F setf=0 -> result=0x0FF0; psr_o unchanged.
- Response backpressure: rsp_ready[1] held low 5 cycles:
  - rsp_valid[1] and the result stay stable.
  - Port0 req_ready stays 0 until the handshake, then is granted in the next IDLE cycle.
- Assert rst during EXEC:
  - rsp_valid = 0 and psr_o = 0 immediately.
  - After release, a pending port1 request loses to port0 if both are valid.
